// File: rtl/serial_parity_receiver.sv
// Serial parity link receiver: start bit, DATA_BITS data bits LSB first, parity bit, stop bit.
// Define SERIAL_PARITY_RECEIVER_ERRCNT_EN to add the saturating ERRCNT error-frame counter.
module serial_parity_receiver #(
   parameter int unsigned DATA_BITS = 8,
   parameter bit          ODD       = 1'b0
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 EN,
   input  logic                 SER,
   output logic [DATA_BITS-1:0] Q,
   output logic                 RDY,
   output logic                 PERR,
   output logic                 FERR,
   output logic                 BUSY
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
   ,
   output logic [7:0]           ERRCNT
`endif
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   localparam logic [4:0] LAST_BIT = 5'(DATA_BITS - 1);

   state_t               state;
   logic [DATA_BITS-1:0] shreg;
   logic [4:0]           cnt;
   logic                 acc;
   logic                 pend_perr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         acc       <= 1'b0;
         pend_perr <= 1'b0;
         Q         <= '0;
         RDY       <= 1'b0;
         PERR      <= 1'b0;
         FERR      <= 1'b0;
         BUSY      <= 1'b0;
      end else begin
         // RDY is a single-cycle strobe whether or not EN is present
         RDY <= 1'b0;
         if (EN) begin
            case (state)
               IDLE: begin
                  if (!SER) begin
                     state <= DATA;
                     cnt   <= '0;
                     acc   <= ODD;
                     BUSY  <= 1'b1;
                  end
               end
               DATA: begin
                  for (int i = 0; i < int'(DATA_BITS); i++) begin
                     if (cnt == 5'(i)) shreg[i] <= SER;
                  end
                  acc <= acc ^ SER;
                  cnt <= cnt + 5'd1;
                  if (cnt == LAST_BIT) state <= PARITY;
               end
               PARITY: begin
                  pend_perr <= acc ^ SER;
                  state     <= STOP;
               end
               STOP: begin
                  Q     <= shreg;
                  PERR  <= pend_perr;
                  FERR  <= ~SER;
                  RDY   <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
   // A frame with both parity and framing errors counts once; the count sticks at 8'hFF
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERRCNT <= '0;
      end else if (EN && state == STOP && (pend_perr || !SER) && ERRCNT != 8'hFF) begin
         ERRCNT <= ERRCNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver: even-parity instance (dut0) and odd-parity instance (dut1).
module tb_serial_parity_receiver;

   typedef struct packed {
      logic [7:0] q;
      logic       perr;
      logic       ferr;
      logic [7:0] errcnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en0 = 1'b0, ser0 = 1'b1;
   logic en1 = 1'b0, ser1 = 1'b1;
   logic [7:0] q0v, q1v;
   logic rdy0, perr0, ferr0, busy0;
   logic rdy1, perr1, ferr1, busy1;
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
   logic [7:0] errcnt0, errcnt1;
`endif

   int checks = 0;
   int failures = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   int mcnt0 = 0;
   int mcnt1 = 0;

   always #5 clk = ~clk;

   serial_parity_receiver #(.DATA_BITS(8), .ODD(1'b0)) dut0 (
      .CLK(clk), .RST(rst), .EN(en0), .SER(ser0),
      .Q(q0v), .RDY(rdy0), .PERR(perr0), .FERR(ferr0), .BUSY(busy0)
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
      , .ERRCNT(errcnt0)
`endif
   );

   serial_parity_receiver #(.DATA_BITS(8), .ODD(1'b1)) dut1 (
      .CLK(clk), .RST(rst), .EN(en1), .SER(ser1),
      .Q(q1v), .RDY(rdy1), .PERR(perr1), .FERR(ferr1), .BUSY(busy1)
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
      , .ERRCNT(errcnt1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: parity error when data ones + parity bit + odd-sense is odd
   task automatic push_exp(input int which, input logic [7:0] data, input logic pbit, input logic sbit);
      exp_t e;
      int odd;
      odd = (which == 1) ? 1 : 0;
      e.q    = data;
      e.perr = 1'(($countones(data) + int'(pbit) + odd) % 2);
      e.ferr = ~sbit;
      if (which == 0) begin
         if ((e.perr || e.ferr) && mcnt0 < 255) mcnt0++;
         e.errcnt = 8'(mcnt0);
         sb0.push_back(e);
      end else begin
         if ((e.perr || e.ferr) && mcnt1 < 255) mcnt1++;
         e.errcnt = 8'(mcnt1);
         sb1.push_back(e);
      end
   endtask

   task automatic set_line(input int which, input logic e, input logic s);
      if (which == 0) begin
         en0 = e; ser0 = s;
      end else begin
         en1 = e; ser1 = s;
      end
   endtask

   task automatic drive_bit(input int which, input logic b, input int gmin, input int gmax);
      int gap;
      gap = int'($urandom_range(gmax, gmin));
      repeat (gap) begin
         @(negedge clk);
         set_line(which, 1'b0, 1'($urandom));
      end
      @(negedge clk);
      set_line(which, 1'b1, b);
   endtask

   task automatic send_frame(input int which, input logic [7:0] data, input logic pbit, input logic sbit,
                             input int nbits, input int gmin, input int gmax);
      logic [10:0] bits;
      bits = {sbit, pbit, data, 1'b0};
      if (nbits == 11) push_exp(which, data, pbit, sbit);
      for (int i = 0; i < nbits; i++) begin
         drive_bit(which, bits[i], gmin, gmax);
         if (i == 5) chk("busy_mid_frame", (which == 0) ? busy0 : busy1, 1);
      end
   endtask

   task automatic idle(input int which, input int n);
      repeat (n) begin
         @(negedge clk);
         set_line(which, 1'b1, 1'b1);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rdy0) begin
         if (sb0.size() == 0) begin
            checks++; failures++;
            $display("FAIL rdy0_unexpected actual=1 required=0 at %0t", $time);
         end else begin
            e = sb0.pop_front();
            chk("q0", q0v, e.q);
            chk("perr0", perr0, e.perr);
            chk("ferr0", ferr0, e.ferr);
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
            chk("errcnt0", errcnt0, e.errcnt);
`endif
         end
      end
      if (rdy1) begin
         if (sb1.size() == 0) begin
            checks++; failures++;
            $display("FAIL rdy1_unexpected actual=1 required=0 at %0t", $time);
         end else begin
            e = sb1.pop_front();
            chk("q1", q1v, e.q);
            chk("perr1", perr1, e.perr);
            chk("ferr1", ferr1, e.ferr);
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
            chk("errcnt1", errcnt1, e.errcnt);
`endif
         end
      end
   end

   initial begin
      logic [7:0] d;
      // Asynchronous reset before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_q", q0v, 0);
      chk("rst_rdy", rdy0, 0);
      chk("rst_perr", perr0, 0);
      chk("rst_ferr", ferr0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_busy1", busy1, 0);
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
      chk("rst_errcnt", errcnt0, 0);
`endif
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(0, 2);

      // Directed frames: good, parity error, framing error
      send_frame(0, 8'hA5, 1'b0, 1'b1, 11, 0, 0);
      idle(0, 1);
      chk("busy_after_frame", busy0, 0);
      send_frame(0, 8'hA5, 1'b1, 1'b1, 11, 0, 0);
      idle(0, 1);
      send_frame(0, 8'hA5, 1'b0, 1'b0, 11, 0, 0);
      idle(0, 1);

      // Back-to-back frames, last one with a parity error
      send_frame(0, 8'h5A, 1'b0, 1'b1, 11, 0, 0);
      send_frame(0, 8'hC3, 1'b0, 1'b1, 11, 0, 0);
      send_frame(0, 8'h81, 1'b1, 1'b1, 11, 0, 0);
      idle(0, 2);

      // Asynchronous reset mid-cycle clears delivered outputs immediately
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_q", q0v, 0);
      chk("arst_perr", perr0, 0);
      chk("arst_busy", busy0, 0);
`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
      chk("arst_errcnt", errcnt0, 0);
`endif
      mcnt0 = 0; mcnt1 = 0;
      @(negedge clk);
      rst = 1'b0;
      idle(0, 2);

      // Load non-zero outputs, then abandon a frame after 4 data bits
      send_frame(0, 8'h96, 1'b1, 1'b0, 11, 0, 0);
      idle(0, 1);
      send_frame(0, 8'hA5, 1'b0, 1'b1, 5, 0, 0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_busy", busy0, 0);
      chk("midrst_q", q0v, 0);
      chk("midrst_rdy", rdy0, 0);
      mcnt0 = 0; mcnt1 = 0;
      @(negedge clk);
      rst = 1'b0;
      set_line(0, 1'b1, 1'b1);
      idle(0, 2);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 11, 0, 0);
      idle(0, 2);

      // Randomized frames with random EN gaps
      repeat (30) begin
         d = 8'($urandom);
         send_frame(0, d, 1'($urandom), ($urandom_range(3, 0) != 0), 11, 0, 2);
         if ($urandom_range(1, 0) != 0) idle(0, int'($urandom_range(2, 1)));
      end
      idle(0, 3);

      // Odd parity, EN once in four cycles
      send_frame(1, 8'h01, 1'b0, 1'b1, 11, 3, 3);
      repeat (4) begin
         @(negedge clk);
         set_line(1, 1'b0, 1'b1);
      end
      idle(1, 2);
      repeat (4) begin
         d = 8'($urandom);
         send_frame(1, d, 1'($urandom), ($urandom_range(3, 0) != 0), 11, 1, 3);
         repeat (3) begin
            @(negedge clk);
            set_line(1, 1'b0, 1'($urandom));
         end
      end
      idle(1, 3);

`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
      // Drive the error counter past saturation
      repeat (258) send_frame(0, 8'($urandom), 1'($urandom), 1'b0, 11, 0, 0);
      idle(0, 2);
`endif

      idle(0, 3);
      chk("sb0_drained", sb0.size(), 0);
      chk("sb1_drained", sb1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_parity_receiver.md
Name: serial_parity_receiver

Overview:
- Receive end of the team's serial parity link; the transmit end is the XOR-tree parity generator.
- Deserialises a framed bit stream: start bit, DATA_BITS data bits LSB first, one parity bit, stop bit.
- Checks parity with a single running-XOR flip-flop, in 74x86 + 74x74 style.
- Presents the parallel word with parity-error and framing-error flags and a one-cycle ready strobe.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 1..16.
- ODD, 0, parity sense: 0 = even parity, 1 = odd parity.

Ports:
- CLK  input  1  single system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  bit-sample enable; one pulse per bit time. Logic advances only on edges where EN=1.
- SER  input  1  serial line; idles high.
- Q  output  DATA_BITS  last received data word.
- RDY  output  1  one-cycle strobe: a frame has completed.
- PERR  output  1  parity error on the last completed frame.
- FERR  output  1  framing error (stop bit = 0) on the last completed frame.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset: async on RST=1. State=IDLE; Q=0, RDY=0, PERR=0, FERR=0, BUSY=0; shift register, bit counter and parity accumulator all cleared.
- EN=0: state, counter, shift register and accumulator hold. RDY still drops after its single cycle.
- IDLE:
  - EN=1 and SER=0: start bit. Go to DATA; counter=0; accumulator=ODD.
  - EN=1 and SER=1: stay in IDLE.
- DATA, on each EN=1:
  - shift register bit[counter] = SER.
  - accumulator ^= SER; counter++.
  - After the DATA_BITS-th bit, go to PARITY.
- PARITY, on EN=1:
  - pending_perr = accumulator ^ SER (1 = mismatch).
  - Go to STOP.
- STOP, on EN=1, all at one edge:
  - Q = shift register.
  - PERR = pending_perr.
  - FERR = ~SER.
  - RDY = 1.
  - Go to IDLE.
- RDY: high exactly one CLK cycle, following the edge that samples the stop bit. Forced to 0 on the next edge regardless of EN.
- Q, PERR, FERR hold until the next frame completes or reset.
- Framing error: the data word is still delivered (Q updated, RDY pulses).
- BUSY = 1 in DATA, PARITY and STOP; 0 in IDLE.
- Back-to-back frames: a start bit on the first EN after STOP is accepted. No idle bit is required.
- Reset mid-frame: the frame is abandoned, no RDY is produced, and all outputs are cleared.
- Bit counter width: 5 bits, sufficient for DATA_BITS up to 16.
- No combinational path from any input to any output.

Optional Feature:
- Macro: SERIAL_PARITY_RECEIVER_ERRCNT_EN.
- When defined:
  - Adds output ERRCNT [7:0].
  - Increments by 1 on each completed frame with PERR or FERR set; a frame with both counts once.
  - Saturates at 8'hFF.
  - Reset value 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Defaults for all scenarios: DATA_BITS=8, ODD=0, EN=1 every cycle.
- Reset check: assert RST mid-cycle, no clock edge -> Q=8'h00, RDY=0, PERR=0, FERR=0, BUSY=0 immediately.
- Good frame: SER sequence 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0, stop 1) -> BUSY high during the frame; RDY high one cycle; Q=8'hA5, PERR=0, FERR=0.
- Parity error: same frame with parity bit 1 -> Q=8'hA5, PERR=1, FERR=0; ERRCNT=1 when the macro is defined.
- Framing error: same frame with stop bit 0 -> Q=8'hA5, PERR=0, FERR=1, RDY still pulses once.
- Reset mid-frame: assert RST after 4 data bits of 0xA5 -> no RDY, BUSY=0, Q=0. Then send a good 0x3C frame (parity 0) -> Q=8'h3C, PERR=0.
- Slow enable: ODD=1, EN pulsed 1 cycle in 4, frame 0x01 with parity bit 0 -> Q=8'h01, PERR=0. RDY lasts exactly 1 CLK cycle, and state is frozen on EN=0 cycles.
